// File: rtl/rv32_regfile_mp.sv
// Multi-read-port integer register file with a sequential clear engine and a write-drop error pulse.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module rv32_regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NRP      = 2,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRP*AW-1:0]    rs_addr,
  output logic [NRP*XLEN-1:0]  rs_data,
  input  logic                 rd_we,
  input  logic [AW-1:0]        rd_addr,
  input  logic [XLEN-1:0]      rd_data,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 wr_err
);

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   ptr_q;
  logic            busy_q;
  logic            wr_err_q;

  // x0 is hardwired to zero and never stored.
  logic [XLEN-1:0] regs [1:NUM_REGS-1];

  logic            wr_valid;
  logic            last_clr;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;

  assign wr_valid = rd_we && (rd_addr != '0);
  assign last_clr = (ptr_q == AW'(NUM_REGS - 1));

  assign busy   = busy_q;
  assign wr_err = wr_err_q;

  // Control FSM; busy and wr_err are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StClear;
      ptr_q    <= AW'(1);
      busy_q   <= 1'b1;
      wr_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wr_err_q <= 1'b0;
          if (clr_req) begin
            state_q <= StClear;
            ptr_q   <= AW'(1);
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          // clr_req is ignored here; the running clear is never restarted.
          wr_err_q <= wr_valid;
          ptr_q    <= ptr_q + AW'(1);
          if (last_clr) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= StClear;
          ptr_q    <= AW'(1);
          busy_q   <= 1'b1;
          wr_err_q <= 1'b0;
        end
      endcase
    end
  end

  // Single array write port shared by the clear engine and architectural writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = rd_addr;
    mem_wdata = rd_data;
    if (!rst) begin
      if (state_q == StClear) begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
      end else if (wr_valid) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      regs[mem_addr] <= mem_wdata;
    end
  end

  for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = rs_addr[gi*AW +: AW];

    always_comb begin
      data = '0;
      if (!busy_q && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if ((state_q == StIdle) && wr_valid && (addr == rd_addr)) begin
          data = rd_data;
        end else begin
          data = regs[addr];
        end
`else
        data = regs[addr];
`endif
      end
    end

    assign rs_data[gi*XLEN +: XLEN] = data;
  end

  // Reads must be masked for the whole clear sequence.
  a_busy_masks_reads: assert property (@(posedge clk) disable iff (rst) busy_q |-> (rs_data == '0));

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// Randomised self-checking bench for rv32_regfile_mp against a cycle-count reference model.
module tb_rv32_regfile_mp;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned NRP      = 2;
  localparam int unsigned AW       = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic                rd_we;
  logic [AW-1:0]       rd_addr;
  logic [XLEN-1:0]     rd_data;
  logic                clr_req;
  logic                busy;
  logic                wr_err;

  rv32_regfile_mp #(
    .XLEN    (XLEN),
    .NUM_REGS(NUM_REGS),
    .NRP     (NRP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rs_addr(rs_addr),
    .rs_data(rs_data),
    .rd_we  (rd_we),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .clr_req(clr_req),
    .busy   (busy),
    .wr_err (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents plus remaining clear cycles.
  logic [XLEN-1:0] mem [NUM_REGS];
  int              clear_left = 0;
  bit              exp_err    = 1'b0;
  bit              mdl_valid  = 1'b0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_read(input int a, input bit we, input int wa,
                                                input logic [XLEN-1:0] wd);
    if (clear_left > 0 || a == 0) return '0;
    if (BYPASS && we && wa != 0 && wa == a) return wd;
    return mem[a];
  endfunction

  // One clock cycle: drive at negedge, check reads, clock, update model, check registered outputs.
  task automatic cyc(input bit r, input bit we, input int wa, input logic [XLEN-1:0] wd,
                     input bit clr, input int a0, input int a1);
    rst     = r;
    rd_we   = we;
    rd_addr = AW'(wa);
    rd_data = wd;
    clr_req = clr;
    rs_addr = {AW'(a1), AW'(a0)};
    #1;
    if (mdl_valid) begin
      check("rd0", rs_data[XLEN-1:0], exp_read(a0, we, wa, wd));
      check("rd1", rs_data[2*XLEN-1:XLEN], exp_read(a1, we, wa, wd));
    end
    @(posedge clk);
    if (r) begin
      clear_left = NUM_REGS - 1;
      exp_err    = 1'b0;
      mdl_valid  = 1'b1;
    end else if (clear_left > 0) begin
      mem[NUM_REGS - clear_left] = '0;
      clear_left--;
      exp_err = we && wa != 0;
    end else begin
      exp_err = 1'b0;
      if (we && wa != 0) mem[wa] = wd;
      if (clr) clear_left = NUM_REGS - 1;
    end
    #1;
    if (mdl_valid) begin
      check("busy", XLEN'(busy), XLEN'(clear_left > 0));
      check("wr_err", XLEN'(wr_err), XLEN'(exp_err));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 0, '0, 1'b0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 0, '0, 1'b0, i, i + 16);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 0, '0, 1'b0, i + 16, i);
  endtask

  // Counts cycles until busy drops; an optional clr_req is injected at cycle clr_at.
  task automatic measure_clear(input string tag, input int clr_at);
    int n;
    n = 0;
    while (busy && n < 64) begin
      cyc(1'b0, 1'b0, 0, '0, (n == clr_at), 1, 2);
      n++;
    end
    check(tag, XLEN'(n), XLEN'(31));
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
    rst = 1'b1; rd_we = 1'b0; rd_addr = '0; rd_data = '0; clr_req = 1'b0; rs_addr = '0;
    @(negedge clk);

    // Reset and clear length
    cyc(1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    measure_clear("clr_len_reset", -1);
    read_all();

    // Basic read/write, x0 discard
    cyc(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 31, 32'h12345678, 1'b0, 5, 0);
    cyc(1'b0, 1'b1, 0, 32'hFFFFFFFF, 1'b0, 5, 31);
    check("x5", rs_data[XLEN-1:0], 32'hDEADBEEF);
    check("x31", rs_data[2*XLEN-1:XLEN], 32'h12345678);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 0, 0);
    check("x0", rs_data[XLEN-1:0], 32'h0);

    // Dropped write during clear cycle 10
    cyc(1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    idle(9);
    cyc(1'b0, 1'b1, 3, 32'hA5A5A5A5, 1'b0, 3, 3);
    check("drop_err_hi", XLEN'(wr_err), 32'h1);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 3, 3);
    check("drop_err_lo", XLEN'(wr_err), 32'h0);
    idle(20);
    check("drop_done", XLEN'(busy), 32'h0);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 3, 3);
    check("x3_zero", rs_data[XLEN-1:0], 32'h0);

    // clr_req with simultaneous write, second request mid-clear
    for (int i = 1; i < NUM_REGS; i++) cyc(1'b0, 1'b1, i, XLEN'(i), 1'b0, i - 1, i);
    cyc(1'b0, 1'b1, 7, 32'h77, 1'b1, 7, 8);
    check("clr_busy", XLEN'(busy), 32'h1);
    measure_clear("clr_len_req", 5);
    read_all();

    // Mid-clear reset restarts the sequence
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 0, 0);
    idle(14);
    cyc(1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    measure_clear("clr_len_rst", -1);

    // Bypass behaviour
    cyc(1'b0, 1'b1, 9, 32'h11, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 9, 32'h22, 1'b0, 9, 9);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 9, 9);
    check("byp_next", rs_data[2*XLEN-1:XLEN], 32'h22);
    rd_we = 1'b1; rd_addr = 5'd9; rd_data = 32'h33; rs_addr = {5'd9, 5'd9};
    #1;
    check("byp_same", rs_data[XLEN-1:0], BYPASS ? 32'h33 : 32'h22);
    cyc(1'b0, 1'b1, 9, 32'h33, 1'b0, 9, 9);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 49) == 0),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
